// File: rtl/key_cmd_sched.sv
// Key-driven SDRAM command scheduler: turns write/read key presses into single-burst
// commands, generates write data, checks read data against the address pattern.
module key_cmd_sched #(
   parameter int CLK_CYC    = 10,
   parameter int BURST_LEN  = 8,
   parameter int ADDR_W     = 24,
   parameter int TIMEOUT_US = 100
) (
   input  logic              sysclk,
   input  logic              rst_n,
   input  logic              key_wr,
   input  logic              key_rd,
   output logic              cmd_req,
   output logic              cmd_wr,
   output logic [ADDR_W-1:0] cmd_addr,
   input  logic              cmd_ack,
   input  logic              cmd_done,
   input  logic              wr_data_req,
   output logic [15:0]       wr_data,
   input  logic              rd_valid,
   input  logic [15:0]       rd_data,
   output logic              busy,
   output logic              err,
   output logic [7:0]        err_cnt,
   output logic              timeout
);

   localparam int TO_CYCLES = TIMEOUT_US * 1000 / CLK_CYC;
   localparam int TO_W      = $clog2(TO_CYCLES + 1);
   localparam int BEAT_W    = $clog2(BURST_LEN + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_XFER = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic              key_wr_s_q, key_wr_p_q, key_rd_s_q, key_rd_p_q;
   logic              press_wr, press_rd;
   logic              pend_wr_q, pend_wr_d, pend_rd_q, pend_rd_d;
   logic              last_wr_q, last_wr_d;
   logic              cmd_wr_q, cmd_wr_d;
   logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic              err_q, err_d, timeout_q, timeout_d;
   logic [7:0]        err_cnt_q, err_cnt_d;

   logic              in_xfer, ack_ev, done_ev, to_term, beat_open;
   logic              wr_beat, rd_beat, sel_wr;
   logic [15:0]       rd_expect;

   // Keys pass through one sampling stage so a key held low across reset release
   // cannot register as a press on the first edge.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         key_wr_s_q <= 1'b1;
         key_wr_p_q <= 1'b1;
         key_rd_s_q <= 1'b1;
         key_rd_p_q <= 1'b1;
      end else begin
         key_wr_s_q <= key_wr;
         key_wr_p_q <= key_wr_s_q;
         key_rd_s_q <= key_rd;
         key_rd_p_q <= key_rd_s_q;
      end
   end

   assign press_wr = key_wr_p_q & ~key_wr_s_q;
   assign press_rd = key_rd_p_q & ~key_rd_s_q;

   assign in_xfer   = (state_q == S_XFER);
   assign ack_ev    = (state_q == S_REQ) & cmd_ack;
   assign done_ev   = in_xfer & cmd_done;
   assign to_term   = in_xfer & (to_cnt_q == TO_W'(TO_CYCLES - 1));
   assign beat_open = (beat_q != BEAT_W'(BURST_LEN));
   assign wr_beat   = in_xfer & cmd_wr_q & wr_data_req & beat_open;
   assign rd_beat   = in_xfer & ~cmd_wr_q & rd_valid & beat_open;
   assign rd_expect = 16'(rd_ptr_q) + 16'(beat_q);
   assign sel_wr    = pend_wr_q & (~pend_rd_q | ~last_wr_q);

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      // NOTE: default first so no path through the block leaves a variable unassigned (no latch).
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (pend_wr_q | pend_rd_q) state_d = S_REQ;
         S_REQ:   if (cmd_ack) state_d = S_XFER;
         S_XFER:  if (cmd_done | to_term) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cmd_req = (state_q == S_REQ);
      busy    = (state_q != S_IDLE);
   end

   always_comb begin
      pend_wr_d  = pend_wr_q;
      pend_rd_d  = pend_rd_q;
      last_wr_d  = last_wr_q;
      cmd_wr_d   = cmd_wr_q;
      cmd_addr_d = cmd_addr_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      beat_d     = beat_q;
      to_cnt_d   = to_cnt_q;
      err_d      = err_q;
      err_cnt_d  = err_cnt_q;
      timeout_d  = timeout_q;

      if ((state_q == S_IDLE) && (pend_wr_q | pend_rd_q)) begin
         cmd_wr_d   = sel_wr;
         cmd_addr_d = sel_wr ? wr_ptr_q : rd_ptr_q;
      end

      if (in_xfer) to_cnt_d = to_cnt_q + TO_W'(1);
      if (wr_beat | rd_beat) beat_d = beat_q + BEAT_W'(1);

      if (ack_ev) begin
         last_wr_d = cmd_wr_q;
         beat_d    = '0;
         to_cnt_d  = '0;
      end

      if (rd_beat && (rd_data != rd_expect)) begin
         err_d = 1'b1;
         if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      end

      // Completion beats a coincident timeout; a timeout leaves the pointer in place.
      if (done_ev) begin
         if (cmd_wr_q) wr_ptr_d = wr_ptr_q + ADDR_W'(BURST_LEN);
         else          rd_ptr_d = rd_ptr_q + ADDR_W'(BURST_LEN);
      end else if (to_term) begin
         timeout_d = 1'b1;
         err_d     = 1'b1;
      end

      if (ack_ev && cmd_wr_q)  pend_wr_d = 1'b0;
      else if (press_wr)       pend_wr_d = 1'b1;
      if (ack_ev && !cmd_wr_q) pend_rd_d = 1'b0;
      else if (press_rd)       pend_rd_d = 1'b1;
   end

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         pend_wr_q  <= 1'b0;
         pend_rd_q  <= 1'b0;
         last_wr_q  <= 1'b0;
         cmd_wr_q   <= 1'b0;
         cmd_addr_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         beat_q     <= '0;
         to_cnt_q   <= '0;
         err_q      <= 1'b0;
         err_cnt_q  <= 8'd0;
         timeout_q  <= 1'b0;
      end else begin
         pend_wr_q  <= pend_wr_d;
         pend_rd_q  <= pend_rd_d;
         last_wr_q  <= last_wr_d;
         cmd_wr_q   <= cmd_wr_d;
         cmd_addr_q <= cmd_addr_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         beat_q     <= beat_d;
         to_cnt_q   <= to_cnt_d;
         err_q      <= err_d;
         err_cnt_q  <= err_cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   assign cmd_wr   = cmd_wr_q;
   assign cmd_addr = cmd_addr_q;
   assign wr_data  = 16'(wr_ptr_q) + 16'(beat_q);
   assign err      = err_q;
   assign err_cnt  = err_cnt_q;
   assign timeout  = timeout_q;

endmodule

// File: tb/tb_key_cmd_sched.sv
// Directed bench for key_cmd_sched: a transaction-level model tracks what the scheduler
// must present each cycle, and each scenario also pins literal expectations.
module tb_key_cmd_sched;

   localparam int CLK_CYC    = 10;
   localparam int BURST_LEN  = 8;
   localparam int ADDR_W     = 4;
   localparam int TIMEOUT_US = 1;
   localparam int TO_CYC     = TIMEOUT_US * 1000 / CLK_CYC;
   localparam int PTR_MOD    = 1 << ADDR_W;

   localparam int M_IDLE = 0;
   localparam int M_REQ  = 1;
   localparam int M_XFER = 2;

   logic              sysclk = 1'b0;
   logic              rst_n = 1'b0;
   logic              key_wr = 1'b1, key_rd = 1'b1;
   logic              cmd_req, cmd_wr;
   logic [ADDR_W-1:0] cmd_addr;
   logic              cmd_ack = 1'b0, cmd_done = 1'b0;
   logic              wr_data_req = 1'b0, rd_valid = 1'b0;
   logic [15:0]       wr_data;
   logic [15:0]       rd_data = 16'h0;
   logic              busy, err, timeout;
   logic [7:0]        err_cnt;

   key_cmd_sched #(
      .CLK_CYC(CLK_CYC), .BURST_LEN(BURST_LEN), .ADDR_W(ADDR_W), .TIMEOUT_US(TIMEOUT_US)
   ) dut (
      .sysclk(sysclk), .rst_n(rst_n), .key_wr(key_wr), .key_rd(key_rd),
      .cmd_req(cmd_req), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr),
      .cmd_ack(cmd_ack), .cmd_done(cmd_done),
      .wr_data_req(wr_data_req), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_data(rd_data),
      .busy(busy), .err(err), .err_cnt(err_cnt), .timeout(timeout)
   );

   always #5 sysclk = ~sysclk;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model state: phase of the current command, pending requests, pointers, flags.
   int m_ph = M_IDLE;
   bit m_pw = 0, m_pr = 0, m_last_wr = 0, m_cwr = 0, m_err = 0, m_to = 0;
   int m_wptr = 0, m_rptr = 0, m_caddr = 0, m_beat = 0, m_tcyc = 0, m_ecnt = 0;
   bit s_wr_cur = 1, s_wr_prev = 1, s_rd_cur = 1, s_rd_prev = 1;
   bit pw_ev, pr_ev, clr_w, clr_r;

   always @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         m_ph = M_IDLE; m_pw = 0; m_pr = 0; m_last_wr = 0; m_cwr = 0;
         m_err = 0; m_to = 0; m_wptr = 0; m_rptr = 0; m_caddr = 0;
         m_beat = 0; m_tcyc = 0; m_ecnt = 0;
         s_wr_cur = 1; s_wr_prev = 1; s_rd_cur = 1; s_rd_prev = 1;
      end else begin
         pw_ev = s_wr_prev && !s_wr_cur;
         pr_ev = s_rd_prev && !s_rd_cur;
         clr_w = 0;
         clr_r = 0;
         case (m_ph)
            M_IDLE: if (m_pw || m_pr) begin
               m_cwr   = m_pw && (!m_pr || !m_last_wr);
               m_caddr = m_cwr ? m_wptr : m_rptr;
               m_ph    = M_REQ;
            end
            M_REQ: if (cmd_ack) begin
               if (m_cwr) clr_w = 1; else clr_r = 1;
               m_last_wr = m_cwr;
               m_beat = 0;
               m_tcyc = 0;
               m_ph = M_XFER;
            end
            default: begin
               if (m_cwr && wr_data_req && m_beat < BURST_LEN) m_beat++;
               if (!m_cwr && rd_valid && m_beat < BURST_LEN) begin
                  if (rd_data != 16'(m_rptr + m_beat)) begin
                     m_err = 1;
                     if (m_ecnt < 255) m_ecnt++;
                  end
                  m_beat++;
               end
               if (cmd_done) begin
                  if (m_cwr) m_wptr = (m_wptr + BURST_LEN) % PTR_MOD;
                  else       m_rptr = (m_rptr + BURST_LEN) % PTR_MOD;
                  m_ph = M_IDLE;
               end else if (m_tcyc + 1 == TO_CYC) begin
                  m_to = 1;
                  m_err = 1;
                  m_ph = M_IDLE;
               end else begin
                  m_tcyc++;
               end
            end
         endcase
         if (clr_w) m_pw = 0; else if (pw_ev) m_pw = 1;
         if (clr_r) m_pr = 0; else if (pr_ev) m_pr = 1;
         s_wr_prev = s_wr_cur; s_wr_cur = key_wr;
         s_rd_prev = s_rd_cur; s_rd_cur = key_rd;
      end
   end

   always @(negedge sysclk) begin
      if (chk_en) begin
         check("busy", 32'(busy), 32'(m_ph != M_IDLE));
         check("cmd_req", 32'(cmd_req), 32'(m_ph == M_REQ));
         if (m_ph == M_REQ) begin
            check("cmd_wr", 32'(cmd_wr), 32'(m_cwr));
            check("cmd_addr", 32'(cmd_addr), 32'(m_caddr));
         end
         check("err", 32'(err), 32'(m_err));
         check("err_cnt", 32'(err_cnt), 32'(m_ecnt));
         check("timeout", 32'(timeout), 32'(m_to));
         if (m_ph == M_XFER && m_cwr && wr_data_req && m_beat < BURST_LEN)
            check("wr_data", 32'(wr_data), 32'(16'(m_wptr + m_beat)));
      end
   end

   task automatic tick();
      @(posedge sysclk);
      #1;
   endtask

   task automatic press(input bit w, input bit r);
      if (w) key_wr = 1'b0;
      if (r) key_rd = 1'b0;
      tick(); tick();
      key_wr = 1'b1;
      key_rd = 1'b1;
      tick(); tick();
   endtask

   task automatic wait_req(input string name);
      int n = 0;
      while (cmd_req !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      check({name, "_req_seen"}, 32'(cmd_req), 32'd1);
   endtask

   // mid: 0 = nothing during XFER, 1 = both keys pressed, 2 = three write presses
   task automatic serve(input string name, input bit exp_wr, input int exp_addr,
                        input int n_beats, input int bad_beat, input int ack_dly, input int mid);
      wait_req(name);
      check({name, "_wr"}, 32'(cmd_wr), 32'(exp_wr));
      check({name, "_addr"}, 32'(cmd_addr), 32'(exp_addr));
      repeat (ack_dly) tick();
      cmd_ack = 1'b1;
      tick();
      cmd_ack = 1'b0;
      if (mid == 1) press(1'b1, 1'b1);
      if (mid == 2) repeat (3) press(1'b1, 1'b0);
      for (int i = 0; i < n_beats; i++) begin
         if (exp_wr) begin
            wr_data_req = 1'b1;
            if (i < BURST_LEN) check({name, "_wd_lit"}, 32'(wr_data), 32'(16'(exp_addr + i)));
         end else begin
            rd_valid = 1'b1;
            rd_data  = 16'(exp_addr + i) ^ ((i == bad_beat || i >= BURST_LEN) ? 16'h0100 : 16'h0000);
         end
         tick();
      end
      wr_data_req = 1'b0;
      rd_valid    = 1'b0;
      cmd_done    = 1'b1;
      tick();
      cmd_done = 1'b0;
      check({name, "_idle"}, 32'(busy), 32'd0);
   endtask

   bit seen;

   initial begin
      repeat (3) @(posedge sysclk);
      #1;
      rst_n  = 1'b1;
      chk_en = 1'b1;
      tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_req", 32'(cmd_req), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_err_cnt", 32'(err_cnt), 32'd0);
      check("rst_timeout", 32'(timeout), 32'd0);
      check("rst_wr_data", 32'(wr_data), 32'd0);

      // first write then reads, second read with beat 3 corrupted plus two surplus beats
      press(1'b1, 1'b0); serve("wr0", 1'b1, 0, 8, -1, 2, 0);
      press(1'b0, 1'b1); serve("rd0", 1'b0, 0, 8, -1, 1, 0);
      check("rd0_err", 32'(err), 32'd0);
      press(1'b0, 1'b1); serve("rd1", 1'b0, 8, 10, 3, 1, 0);
      check("rd1_err", 32'(err), 32'd1);
      check("rd1_err_cnt", 32'(err_cnt), 32'd1);

      // second write at 8; the write pointer then wraps to 0
      press(1'b1, 1'b0); serve("wr1", 1'b1, 8, 8, -1, 1, 0);

      // reset in the middle of a transfer
      press(1'b1, 1'b0);
      wait_req("abort");
      check("abort_addr", 32'(cmd_addr), 32'd0);
      cmd_ack = 1'b1; tick(); cmd_ack = 1'b0;
      wr_data_req = 1'b1; tick(); tick(); wr_data_req = 1'b0;
      rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_err", 32'(err), 32'd0);
      check("abort_err_cnt", 32'(err_cnt), 32'd0);

      // simultaneous presses from reset, then a second tie during the write transfer
      press(1'b1, 1'b1);
      serve("tie_w0", 1'b1, 0, 8, -1, 1, 1);
      serve("tie_r0", 1'b0, 0, 8, -1, 1, 0);
      serve("tie_w1", 1'b1, 8, 8, -1, 1, 0);

      // three write presses in one transfer yield exactly one follow-up write
      press(1'b1, 1'b0); serve("wr3", 1'b1, 0, 8, -1, 1, 2);
      serve("wr3_extra", 1'b1, 8, 8, -1, 1, 0);
      seen = 1'b0;
      repeat (20) begin
         tick();
         if (cmd_req) seen = 1'b1;
      end
      check("no_extra_req", 32'(seen), 32'd0);

      // completion on the very cycle the timeout would fire
      press(1'b1, 1'b0);
      wait_req("edge_done");
      check("edge_done_addr", 32'(cmd_addr), 32'd0);
      cmd_ack = 1'b1; tick(); cmd_ack = 1'b0;
      repeat (TO_CYC - 1) tick();
      cmd_done = 1'b1; tick(); cmd_done = 0;
      check("edge_done_busy", 32'(busy), 32'd0);
      check("edge_done_timeout", 32'(timeout), 32'd0);
      check("edge_done_err", 32'(err), 32'd0);

      // withheld completion: timeout, pointer kept, stray handshakes ignored
      press(1'b1, 1'b0);
      wait_req("to");
      check("to_addr", 32'(cmd_addr), 32'd8);
      cmd_ack = 1'b1; tick(); cmd_ack = 1'b0;
      repeat (TO_CYC + 5) tick();
      check("to_timeout", 32'(timeout), 32'd1);
      check("to_err", 32'(err), 32'd1);
      check("to_busy", 32'(busy), 32'd0);
      cmd_done = 1'b1; cmd_ack = 1'b1; tick();
      cmd_done = 1'b0; cmd_ack = 1'b0; tick();
      check("stray_busy", 32'(busy), 32'd0);
      press(1'b1, 1'b0); serve("wr_after_to", 1'b1, 8, 8, -1, 1, 0);

      repeat (3) tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
      $fatal(1);
   end

endmodule
